lap_timer_core: RTL

LAP_TIMER_CORE -- requirements
Module: lap_timer_core

---
 rtl/lap_timer_core.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/lap_timer_core.sv
// Stopwatch core: BCD mm:ss:cc timer with run/pause FSM, up/down counting,
// synchronised push-button inputs and a lap-capture FIFO.
module lap_timer_core #(
  parameter int CLK_FREQ  = 1000000,
  parameter int TICK_FREQ = 100,
  parameter int LAP_DEPTH = 4,
  parameter int WRAP      = 1
) (
  input  logic                         clk,
  input  logic                         res,
  input  logic                         start_stop,
  input  logic                         lap,
  input  logic                         clear,
  input  logic                         mode_down,
  input  logic                         load_en,
  input  logic [23:0]                  load_time,
  output logic [23:0]                  time_bcd,
  output logic                         running,
  output logic                         tick,
  output logic                         done,
  output logic [23:0]                  lap_data,
  output logic                         lap_valid,
  input  logic                         lap_ready,
  output logic [$clog2(LAP_DEPTH):0]   lap_count,
  output logic                         lap_overflow
);

  localparam int DIV = CLK_FREQ / TICK_FREQ;
  localparam int DW  = $clog2(DIV);
  localparam int AW  = $clog2(LAP_DEPTH);
  localparam int CW  = AW + 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(LAP_DEPTH);
  localparam logic [23:0]   T_MAX    = 24'h595999;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;

  // Tens-of-seconds and tens-of-minutes digits stop at 5, all others at 9.
  function automatic logic [3:0] f_lim(input int i);
    return (i == 3 || i == 5) ? 4'd5 : 4'd9;
  endfunction

  function automatic logic f_valid(input logic [23:0] t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 6; i++)
      if (t[i*4 +: 4] > f_lim(i)) ok = 1'b0;
    return ok;
  endfunction

  function automatic logic [23:0] f_inc(input logic [23:0] t);
    logic [23:0] r;
    logic        c;
    r = t;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == f_lim(i)) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [23:0] f_dec(input logic [23:0] t);
    logic [23:0] r;
    logic        b;
    r = t;
    b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (b) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = f_lim(i);
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          b = 1'b0;
        end
      end
    end
    return r;
  endfunction

  logic [2:0]          r_sync1, r_sync2, r_sdly, r_pulse;
  logic [1:0]          r_state;
  logic [23:0]         r_time;
  logic [DW-1:0]       r_div;
  logic                r_done;
  logic                r_down;
  logic [23:0]         r_mem [LAP_DEPTH];
  logic [AW-1:0]       r_wp, r_rp;
  logic [CW-1:0]       r_cnt;
  logic                r_ovf;

  logic                w_st, w_lp, w_cl;
  logic                w_tick, w_term, w_stop, w_load_ok, w_start_blk;
  logic [23:0]         w_next_t;
  logic                w_full, w_pop, w_push, w_drop, w_fclr;

  // Button inputs: {clear, lap, start_stop} -> 2-FF sync -> registered rising-edge pulse
  always_ff @(posedge clk) begin
    if (res) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sdly  <= '0;
      r_pulse <= '0;
    end else begin
      r_sync1 <= {clear, lap, start_stop};
      r_sync2 <= r_sync1;
      r_sdly  <= r_sync2;
      r_pulse <= r_sync2 & ~r_sdly;
    end
  end

  assign w_st = r_pulse[0];
  assign w_lp = r_pulse[1];
  assign w_cl = r_pulse[2];

  assign w_tick      = (r_state == S_RUN) && (r_div == DIV_LAST);
  assign w_next_t    = r_down ? f_dec(r_time)
                     : ((r_time == T_MAX && WRAP == 0) ? r_time : f_inc(r_time));
  assign w_term      = w_tick && (r_down ? (w_next_t == 24'h0) : (r_time == T_MAX));
  assign w_stop      = w_term && (r_down || WRAP == 0);
  assign w_load_ok   = load_en && (r_state != S_RUN) && f_valid(load_time);
  assign w_start_blk = mode_down && (r_time == 24'h0);

  // Run/pause FSM, tick divider and time register
  always_ff @(posedge clk) begin
    if (res) begin
      r_state <= S_IDLE;
      r_time  <= '0;
      r_div   <= '0;
      r_done  <= 1'b0;
      r_down  <= 1'b0;
    end else begin
      r_done <= w_term;
      if (r_state != S_RUN) r_down <= mode_down;
      case (r_state)
        S_RUN: begin
          if (w_tick) begin
            r_div  <= '0;
            r_time <= w_next_t;
          end else begin
            r_div <= r_div + DW'(1);
          end
          if (w_stop || w_st) r_state <= S_PAUSE;
        end
        S_IDLE, S_PAUSE: begin
          if (w_cl) begin
            r_state <= S_IDLE;
            r_time  <= '0;
            r_div   <= '0;
          end else if (w_load_ok) begin
            r_state <= S_PAUSE;
            r_time  <= load_time;
            r_div   <= '0;
          end else if (w_st && !w_start_blk) begin
            r_state <= S_RUN;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_time  <= '0;
          r_div   <= '0;
        end
      endcase
    end
  end

  assign w_full = (r_cnt == DEPTH_C);
  assign w_pop  = (r_cnt != '0) && lap_ready;
  assign w_push = (r_state == S_RUN) && w_lp && (!w_full || w_pop);
  assign w_drop = (r_state == S_RUN) && w_lp && w_full && !w_pop;
  assign w_fclr = w_cl && (r_state != S_RUN);

  // Lap FIFO control; a full FIFO accepts a push only alongside a pop
  always_ff @(posedge clk) begin
    if (res || w_fclr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
      if (w_drop) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= r_time;
  end

  assign time_bcd     = r_time;
  assign running      = (r_state == S_RUN);
  assign tick         = w_tick;
  assign done         = r_done;
  assign lap_valid    = (r_cnt != '0);
  assign lap_data     = lap_valid ? r_mem[r_rp] : 24'h0;
  assign lap_count    = r_cnt;
  assign lap_overflow = r_ovf;

endmodule
